// File: rtl/jk_pkg.sv
// Shared J/K command encoding for the JK storage elements and the counters
// that drive them.
package jk_pkg;

    typedef logic [1:0] jk_cmd_t;

    localparam jk_cmd_t JK_HOLD = 2'b00;
    localparam jk_cmd_t JK_CLR  = 2'b01;
    localparam jk_cmd_t JK_SET  = 2'b10;
    localparam jk_cmd_t JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_ff.sv
// Edge-triggered JK flip-flop with asynchronous active-high reset (q=0, qbar=1).
module jk_ff
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            case (jk_cmd_t'({j, k}))
                JK_HOLD: r_q <= r_q;
                JK_CLR:  r_q <= 1'b0;
                JK_SET:  r_q <= 1'b1;
                default: r_q <= ~r_q;
            endcase
        end
    end

    assign q    = r_q;
    assign qbar = ~r_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter built from JK flip-flops, with parallel load,
// cascadable terminal count, registered wrap pulse and sticky illegal-load flag.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qbar;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH:0]   w_cur_ext;
    logic [WIDTH:0]   w_din_ext;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic             w_in_range;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_din_legal;
    logic             w_count_wrap;
    jk_cmd_t          w_cmd [WIDTH];

    logic r_wrap;
    logic r_err;

    // Candidates are one bit wider so the modulo compare sees the carry/borrow.
    assign w_cur_ext   = {1'b0, w_q};
    assign w_din_ext   = {1'b0, din};
    assign w_inc       = w_cur_ext + ONE_EXT;
    assign w_dec       = w_cur_ext - ONE_EXT;
    assign w_in_range  = (w_cur_ext < MOD_EXT);
    assign w_at_max    = (w_cur_ext == MAX_EXT);
    assign w_at_zero   = &w_qbar;
    assign w_din_legal = (w_din_ext < MOD_EXT);

    always_comb begin
        w_next       = w_q;
        w_count_wrap = 1'b0;
        if (up) begin
            if (!w_in_range) begin
                w_next = '0;
            end else if (w_inc == MOD_EXT) begin
                w_next       = '0;
                w_count_wrap = 1'b1;
            end else begin
                w_next = w_inc[WIDTH-1:0];
            end
        end else begin
            if (!w_in_range) begin
                w_next = MAX_EXT[WIDTH-1:0];
            end else if (w_dec[WIDTH]) begin
                w_next       = MAX_EXT[WIDTH-1:0];
                w_count_wrap = 1'b1;
            end else begin
                w_next = w_dec[WIDTH-1:0];
            end
        end
    end

    assign w_diff = w_next ^ w_q;

    // An illegal load leaves every bit on HOLD and suppresses counting too.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_cmd[i] = JK_HOLD;
            if (load) begin
                if (w_din_legal) begin
                    w_cmd[i] = {din[i], ~din[i]};
                end
            end else if (en) begin
                w_cmd[i] = {w_diff[i], w_diff[i]};
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        jk_ff u_ff (
            .clk  (clk),
            .rst  (rst),
            .j    (w_cmd[g][1]),
            .k    (w_cmd[g][0]),
            .q    (w_q[g]),
            .qbar (w_qbar[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_wrap <= !load && en && w_count_wrap;
            if (load && !w_din_legal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign count = w_q;
    assign tc    = en & ((up & w_at_max) | (~up & w_at_zero));
    assign wrap  = r_wrap;
    assign err   = r_err;

endmodule
